// File: rtl/data_28x3_ctrl.sv
// Sweep-initialises a 28x3 register file, then arbitrates its write port and serves registered reads.
// Latency: writes land at the next edge; read response is one cycle after the request; sweep takes 28 cycles.
// Backpressure: write readies drop to 0 during the sweep, on flush cycles, and for the requester that loses contention.
module data_28x3_ctrl #(
    parameter int              ENTRIES    = 28,
    parameter int              WIDTH      = 3,
    parameter int              AW         = 5,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_flush,
    output logic             io_ready,
    input  logic             io_w0_valid,
    output logic             io_w0_ready,
    input  logic [AW-1:0]    io_w0_addr,
    input  logic [WIDTH-1:0] io_w0_data,
    input  logic             io_w1_valid,
    output logic             io_w1_ready,
    input  logic [AW-1:0]    io_w1_addr,
    input  logic [WIDTH-1:0] io_w1_data,
    input  logic             io_r_valid,
    input  logic [AW-1:0]    io_r_addr,
    output logic             io_r_resp_valid,
    output logic [WIDTH-1:0] io_r_resp_data,
    output logic             io_r_resp_oob,
    output logic [AW-1:0]    mem_R0_addr,
    output logic             mem_R0_en,
    input  logic [WIDTH-1:0] mem_R0_data,
    output logic [AW-1:0]    mem_W0_addr,
    output logic             mem_W0_en,
    output logic [WIDTH-1:0] mem_W0_data
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // One extra bit so the range check works even when ENTRIES == 2**AW.
    localparam logic [AW:0]   ENT_LIM  = (AW+1)'(ENTRIES);
    localparam logic [AW-1:0] LAST_ROW = AW'(ENTRIES - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             rr_q, rr_d;          // 0: w0 wins the next contention, 1: w1 wins
    logic             resp_vld_q, resp_vld_d;
    logic [WIDTH-1:0] resp_dat_q, resp_dat_d;
    logic             resp_oob_q, resp_oob_d;
    logic             g0, g1, r_oob;

    assign io_r_resp_valid = resp_vld_q;
    assign io_r_resp_data  = resp_dat_q;
    assign io_r_resp_oob   = resp_oob_q;
    assign io_w0_ready     = g0;
    assign io_w1_ready     = g1;
    assign mem_R0_addr     = io_r_addr;
    assign r_oob           = ({1'b0, io_r_addr} >= ENT_LIM);

    // Next-state, arbitration and memory-port drive; reset cycle is held quiet on the memory side.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        resp_vld_d  = 1'b0;
        resp_dat_d  = resp_dat_q;
        resp_oob_d  = resp_oob_q;
        io_ready    = 1'b0;
        g0          = 1'b0;
        g1          = 1'b0;
        mem_R0_en   = 1'b0;
        mem_W0_en   = 1'b0;
        mem_W0_addr = '0;
        mem_W0_data = '0;
        if (!reset) begin
            case (state_q)
                ST_INIT: begin
                    // Flush is deliberately not looked at here: the sweep always completes.
                    mem_W0_en   = 1'b1;
                    mem_W0_addr = cnt_q;
                    mem_W0_data = INIT_VALUE;
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    io_ready = 1'b1;
                    if (io_flush) begin
                        // Flush cycle is dead: no grant, no read; pointer survives.
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else begin
                        g0 = io_w0_valid && (!io_w1_valid || !rr_q);
                        g1 = io_w1_valid && (!io_w0_valid ||  rr_q);
                        if (io_w0_valid && io_w1_valid) begin
                            rr_d = ~rr_q;
                        end
                        if (g0) begin
                            mem_W0_addr = io_w0_addr;
                            mem_W0_data = io_w0_data;
                            mem_W0_en   = ({1'b0, io_w0_addr} < ENT_LIM);
                        end else if (g1) begin
                            mem_W0_addr = io_w1_addr;
                            mem_W0_data = io_w1_data;
                            mem_W0_en   = ({1'b0, io_w1_addr} < ENT_LIM);
                        end
                        if (io_r_valid) begin
                            mem_R0_en  = 1'b1;
                            resp_vld_d = 1'b1;
                            resp_oob_d = r_oob;
                            resp_dat_d = r_oob ? '0 : mem_R0_data;
                        end
                    end
                end
            endcase
        end
    end

    // State, sweep counter, round-robin pointer and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            resp_oob_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            resp_oob_q <= resp_oob_d;
        end
    end

endmodule

// File: tb/tb_data_28x3_ctrl.sv
// Directed bench for data_28x3_ctrl with a behavioural 28x3 memory macro attached.
// Inputs change 1ns after the rising edge; combinational outputs are checked on the falling edge.
// Registered responses are checked 1ns after the edge that captures them.
module tb_data_28x3_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_flush;
    logic       io_ready;
    logic       io_w0_valid, io_w0_ready;
    logic [4:0] io_w0_addr;
    logic [2:0] io_w0_data;
    logic       io_w1_valid, io_w1_ready;
    logic [4:0] io_w1_addr;
    logic [2:0] io_w1_data;
    logic       io_r_valid;
    logic [4:0] io_r_addr;
    logic       io_r_resp_valid;
    logic [2:0] io_r_resp_data;
    logic       io_r_resp_oob;
    logic [4:0] mem_R0_addr;
    logic       mem_R0_en;
    logic [2:0] mem_R0_data;
    logic [4:0] mem_W0_addr;
    logic       mem_W0_en;
    logic [2:0] mem_W0_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    data_28x3_ctrl dut (
        .clock(clock), .reset(reset), .io_flush(io_flush), .io_ready(io_ready),
        .io_w0_valid(io_w0_valid), .io_w0_ready(io_w0_ready),
        .io_w0_addr(io_w0_addr), .io_w0_data(io_w0_data),
        .io_w1_valid(io_w1_valid), .io_w1_ready(io_w1_ready),
        .io_w1_addr(io_w1_addr), .io_w1_data(io_w1_data),
        .io_r_valid(io_r_valid), .io_r_addr(io_r_addr),
        .io_r_resp_valid(io_r_resp_valid), .io_r_resp_data(io_r_resp_data),
        .io_r_resp_oob(io_r_resp_oob),
        .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
        .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en), .mem_W0_data(mem_W0_data)
    );

    // Memory macro model: async read, write at the edge; out-of-range reads return all ones.
    logic [2:0] mem [0:27];
    initial for (int k = 0; k < 28; k++) mem[k] = 3'b101;
    always @(posedge clock) if (mem_W0_en && mem_W0_addr < 5'd28) mem[mem_W0_addr] <= mem_W0_data;
    assign mem_R0_data = (mem_R0_addr < 5'd28) ? mem[mem_R0_addr] : 3'b111;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_flush = 0; io_w0_valid = 0; io_w1_valid = 0; io_r_valid = 0;
        io_w0_addr = 0; io_w0_data = 0; io_w1_addr = 0; io_w1_data = 0; io_r_addr = 0;
    endtask

    // Checks sweep rows 0.. while pushing write/read traffic that must be ignored.
    // Pulses flush on row flush_at; leaves the loop without advancing at row stop_at.
    task automatic sweep_chk(input int flush_at, input int stop_at);
        for (int i = 0; i < 28; i++) begin
            io_flush = (i == flush_at);
            io_w0_valid = 1; io_w0_addr = 5'd1; io_w0_data = 3'd4;
            io_r_valid = 1; io_r_addr = 5'd1;
            @(negedge clock);
            chk("sweep_en",    32'(mem_W0_en), 1);
            chk("sweep_addr",  32'(mem_W0_addr), i);
            chk("sweep_data",  32'(mem_W0_data), 0);
            chk("sweep_ready", 32'(io_ready), 0);
            chk("sweep_w0rdy", 32'(io_w0_ready), 0);
            if (i == stop_at) break;
            tick();
            chk("sweep_noresp", 32'(io_r_resp_valid), 0);
        end
        if (stop_at >= 28) begin
            idle();
            @(negedge clock);
            chk("ready_c28", 32'(io_ready), 1);
            chk("no_wr_c28", 32'(mem_W0_en), 0);
            tick();
        end
    endtask

    task automatic rd_all(input logic [2:0] v);
        for (int i = 0; i < 28; i++) begin
            io_r_valid = 1; io_r_addr = 5'(i);
            tick();
            chk("rd_vld",  32'(io_r_resp_valid), 1);
            chk("rd_data", 32'(io_r_resp_data), 32'(v));
            chk("rd_oob",  32'(io_r_resp_oob), 0);
        end
        io_r_valid = 0;
    endtask

    // One cycle with both requesters valid; want0 says whether w0 should win.
    task automatic contend(input logic want0, input logic [4:0] a0, input logic [2:0] d0,
                           input logic [4:0] a1, input logic [2:0] d1);
        io_w0_valid = 1; io_w0_addr = a0; io_w0_data = d0;
        io_w1_valid = 1; io_w1_addr = a1; io_w1_data = d1;
        @(negedge clock);
        chk("rr_w0rdy", 32'(io_w0_ready), 32'(want0));
        chk("rr_w1rdy", 32'(io_w1_ready), 32'(!want0));
        chk("rr_wdata", 32'(mem_W0_data), want0 ? 32'(d0) : 32'(d1));
        tick();
        io_w0_valid = 0; io_w1_valid = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        // Reset cycle values.
        chk("rst_ready", 32'(io_ready), 0);
        chk("rst_rvld",  32'(io_r_resp_valid), 0);
        chk("rst_rdata", 32'(io_r_resp_data), 0);
        chk("rst_roob",  32'(io_r_resp_oob), 0);
        @(negedge clock);
        chk("rst_wen",   32'(mem_W0_en), 0);
        tick();
        reset = 0;

        // Initial sweep and readback.
        sweep_chk(-1, 99);
        rd_all(3'd0);

        // Contention: alternate w0,w1,w0,w1, last writer (w1, data 2) wins row 3.
        for (int k = 0; k < 4; k++) contend(k % 2 == 0, 5'd3, 3'd5, 5'd3, 3'd2);
        io_r_valid = 1; io_r_addr = 5'd3;
        tick();
        io_r_valid = 0;
        chk("row3_data", 32'(io_r_resp_data), 2);

        // Same-cycle read/write: pre-write value, then new value.
        io_w0_valid = 1; io_w0_addr = 5'd7; io_w0_data = 3'd6;
        io_r_valid = 1; io_r_addr = 5'd7;
        tick();
        io_w0_valid = 0;
        chk("rw_old", 32'(io_r_resp_data), 0);
        tick();
        io_r_valid = 0;
        chk("rw_new_vld", 32'(io_r_resp_valid), 1);
        chk("rw_new", 32'(io_r_resp_data), 6);

        // Out-of-range write dropped, out-of-range read flagged.
        io_w1_valid = 1; io_w1_addr = 5'd30; io_w1_data = 3'd3;
        io_r_valid = 1; io_r_addr = 5'd29;
        @(negedge clock);
        chk("oob_w1rdy", 32'(io_w1_ready), 1);
        chk("oob_wen",   32'(mem_W0_en), 0);
        tick();
        idle();
        chk("oob_rvld",  32'(io_r_resp_valid), 1);
        chk("oob_rdata", 32'(io_r_resp_data), 0);
        chk("oob_flag",  32'(io_r_resp_oob), 1);

        // Fill every row with 7, then one contention (w0 wins, pointer -> w1).
        for (int i = 0; i < 28; i++) begin
            io_w0_valid = 1; io_w0_addr = 5'(i); io_w0_data = 3'd7;
            tick();
        end
        io_w0_valid = 0;
        io_r_valid = 1; io_r_addr = 5'd5;
        tick();
        io_r_valid = 0;
        chk("fill_row5", 32'(io_r_resp_data), 7);
        contend(1'b1, 5'd0, 3'd7, 5'd1, 3'd7);

        // Flush cycle grants nothing and accepts no read.
        io_flush = 1; io_w0_valid = 1; io_w0_addr = 5'd2; io_w0_data = 3'd1;
        io_r_valid = 1; io_r_addr = 5'd2;
        @(negedge clock);
        chk("fl_w0rdy", 32'(io_w0_ready), 0);
        chk("fl_wen",   32'(mem_W0_en), 0);
        chk("fl_ren",   32'(mem_R0_en), 0);
        tick();
        idle();
        chk("fl_noresp", 32'(io_r_resp_valid), 0);
        // Re-sweep with a second flush at row 10 that must be ignored.
        sweep_chk(10, 99);
        rd_all(3'd0);
        // Pointer survived the flush: w1 wins first, then w0.
        contend(1'b0, 5'd4, 3'd1, 5'd4, 3'd2);
        contend(1'b1, 5'd4, 3'd1, 5'd4, 3'd2);

        // Reset at sweep row 10: restart from row 0 with pointer back to w0.
        reset = 1;
        tick();
        reset = 0;
        sweep_chk(-1, 10);
        reset = 1;
        @(negedge clock);
        chk("midrst_wen", 32'(mem_W0_en), 0);
        tick();
        idle();
        reset = 0;
        sweep_chk(-1, 99);
        contend(1'b1, 5'd6, 3'd3, 5'd6, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
